// File: rtl/binmul_pkg.sv
// binmul_pkg: shared widths, state encoding and counter width for the multiplier.
package binmul_pkg;
  localparam int A_W = 3;
  localparam int B_W = 4;
  localparam int P_W = A_W + B_W;
  localparam int CNT_W = $clog2(A_W) + 1;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/binmul_if.sv
// binmul_if: start/done handshake and operand/product bus of the multiplier.
interface binmul_if;
  import binmul_pkg::*;
  logic start_i;
  logic [A_W-1:0] a_i;
  logic [B_W-1:0] b_i;
  logic [P_W-1:0] c_o;
  logic busy_o;
  logic done_o;
  modport master (output start_i, a_i, b_i, input c_o, busy_o, done_o);
  modport slave (input start_i, a_i, b_i, output c_o, busy_o, done_o);
endinterface

// File: rtl/binmul_pp_row.sv
// binmul_pp_row: one partial-product row (b gated by an a bit, shifted by SH) added onto acc.
module binmul_pp_row
  import binmul_pkg::*;
#(
  parameter int SH = 0
) (
  input  logic [P_W-1:0] b_i,
  input  logic           bit_i,
  input  logic [P_W-1:0] acc_i,
  output logic [P_W-1:0] sum_o
);
  assign sum_o = acc_i + (bit_i ? (b_i << SH) : '0);
endmodule

// File: rtl/binary_multiplier_core.sv
// binary_multiplier_core: unsigned A_W x B_W multiplier, shift-add FSM by default;
// defining BINMUL_ARRAY_EN swaps in a single-cycle registered array product.
module binary_multiplier_core
  import binmul_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  binmul_if.slave  bus
);
  logic [P_W-1:0] c_q, c_d;
  logic done_q, done_d;
`ifdef BINMUL_ARRAY_EN
  logic [P_W-1:0] psum [A_W+1];
  assign psum[0] = '0;
  for (genvar i = 0; i < A_W; i++) begin : g_row
    binmul_pp_row #(.SH(i)) u_row (
      .b_i  (P_W'(bus.b_i)),
      .bit_i(bus.a_i[i]),
      .acc_i(psum[i]),
      .sum_o(psum[i+1])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    c_d    = bus.start_i ? psum[A_W] : c_q;
    done_d = bus.start_i;
  end
  assign bus.busy_o = 1'b0;
`else
  state_e state_q, state_d;
  logic [A_W-1:0] a_sh_q, a_sh_d;
  logic [P_W-1:0] b_sh_q, b_sh_d, acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic idle, last;
  binmul_pp_row #(.SH(0)) u_row (
    .b_i  (b_sh_q),
    .bit_i(a_sh_q[0]),
    .acc_i(acc_q),
    .sum_o(sum)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end
  assign idle = state_q == IDLE;
  assign last = !idle && cnt_q == CNT_W'(A_W - 1);
  always_comb begin
    state_d = idle ? (bus.start_i ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  // operands are loaded only on an accepted start, so bus changes during RUN are ignored
  always_comb begin
    a_sh_d = idle ? (bus.start_i ? bus.a_i : a_sh_q) : a_sh_q >> 1;
    b_sh_d = idle ? (bus.start_i ? P_W'(bus.b_i) : b_sh_q) : b_sh_q << 1;
    acc_d  = idle ? (bus.start_i ? '0 : acc_q) : sum;
    cnt_d  = idle ? '0 : cnt_q + 1'b1;
    c_d    = last ? sum : c_q;
    done_d = last;
  end
  assign bus.busy_o = !idle;
`endif
  assign bus.c_o    = c_q;
  assign bus.done_o = done_q;
endmodule

// File: tb/tb_binary_multiplier_core.sv
// tb_binary_multiplier_core: directed, exhaustive and random checks of the multiplier against a*b.
module tb_binary_multiplier_core;
  import binmul_pkg::*;
`ifdef BINMUL_ARRAY_EN
  localparam int LAT = 0, BUSY_N = 0, IVL = 1;
`else
  localparam int LAT = A_W, BUSY_N = A_W, IVL = A_W + 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_assert = 0;
  int n_fail = 0;
  binmul_if bif ();
  binary_multiplier_core dut (.clk(clk), .rst(rst), .bus(bif));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb = 0;
    while (!bif.done_o && lat < 20) begin
      if (bif.busy_o) nb++;
      tick;
      lat++;
    end
  endtask

  task automatic run_op(input int a, input int b, input string tag);
    int lat, nb;
    bif.a_i = A_W'(a);
    bif.b_i = B_W'(b);
    bif.start_i = 1'b1;
    tick;
    bif.start_i = 1'b0;
    wait_done(lat, nb);
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_c"}, bif.c_o, a * b);
    check({tag, "_busy"}, nb, BUSY_N);
    tick;
    check({tag, "_pulse"}, bif.done_o, 0);
  endtask

  initial begin
    int lat, nb, seen, ivl;
    bif.start_i = 1'b0;
    bif.a_i = '0;
    bif.b_i = '0;
    tick;
    tick;
    check("rst_c", bif.c_o, 0);
    check("rst_busy", bif.busy_o, 0);
    check("rst_done", bif.done_o, 0);
    rst = 1'b0;
    tick;
    check("idle_done", bif.done_o, 0);
    run_op(6, 10, "d60");
    run_op(2, 15, "d30");
    run_op(7, 6, "d42");
    run_op(0, 15, "a0");
    run_op(7, 0, "b0");
    run_op(7, 15, "max");
    for (int a = 0; a < (1 << A_W); a++)
      for (int b = 0; b < (1 << B_W); b++)
        run_op(a, b, $sformatf("sweep_%0d_%0d", a, b));
    for (int i = 0; i < 20; i++)
      run_op(int'($urandom_range(0, (1 << A_W) - 1)), int'($urandom_range(0, (1 << B_W) - 1)), $sformatf("rnd%0d", i));
`ifndef BINMUL_ARRAY_EN
    bif.a_i = 3'd5;
    bif.b_i = 4'd9;
    bif.start_i = 1'b1;
    tick;
    bif.a_i = 3'd7;
    bif.b_i = 4'd15;
    tick;
    bif.start_i = 1'b0;
    wait_done(lat, nb);
    check("midrun_lat", lat, LAT - 1);
    check("midrun_c", bif.c_o, 45);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (bif.done_o) seen++;
    end
    check("midrun_nodone", seen, 0);
    check("midrun_hold", bif.c_o, 45);
    run_op(3, 3, "after_mid");
`endif
    bif.a_i = 3'd7;
    bif.b_i = 4'd15;
    bif.start_i = 1'b1;
    tick;
    bif.start_i = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_c", bif.c_o, 0);
    check("abort_busy", bif.busy_o, 0);
    check("abort_done", bif.done_o, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bif.done_o) seen++;
    end
    check("abort_nodone", seen, 0);
    check("abort_c_held", bif.c_o, 0);
    run_op(7, 15, "post_abort");
    bif.a_i = 3'd3;
    bif.b_i = 4'd5;
    bif.start_i = 1'b1;
    tick;
    wait_done(lat, nb);
    check("held_first", lat, LAT);
    tick;
    ivl = 1;
    while (!bif.done_o && ivl < 20) begin
      tick;
      ivl++;
    end
    check("held_ivl", ivl, IVL);
    check("held_c", bif.c_o, 15);
    bif.start_i = 1'b0;
    for (int i = 0; i < A_W + 2; i++) tick;
    check("drain_busy", bif.busy_o, 0);
    check("drain_done", bif.done_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
